kyber_encrypt: RTL and testbench
================================

Name: kyber_encrypt

Overview:
- Baby-Kyber encryptor: the transmit-side counterpart of the decryptor. Ring Z_Q[x]/(x^4+1), module rank 2.
- Computes u_i = sum_j A[j][i]*r_j + e1_i for i = 0,1, and v = sum_j t_j*r_j + e2 + encode(m).
- A single shared multiply-accumulate unit is time-multiplexed over all coefficient products.
- Output ciphertext layout matches the decryptor input: ciphertext[0][i] = u_i, ciphertext[1][0] = v.

Parameters:
- Q, 17, coefficient modulus.
- HALF_Q, 9, encoding of message bit 1, equal to round(Q/2).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin encryption; sampled only in IDLE.
- message  in  4  plaintext bits; bit i maps to coefficient x^i.
- pk_a  in  signed 32 [1:0][1:0][3:0]  public matrix A[row][col][coef].
- pk_t  in  signed 32 [1:0][3:0]  public vector t.
- r_vec  in  signed 32 [1:0][3:0]  ephemeral secret r.
- e1  in  signed 32 [1:0][3:0]  noise added to u.
- e2  in  signed 32 [3:0]  noise added to v.
- ciphertext  out  signed 32 [1:0][1:0][3:0]  result; all coefficients in [0,Q-1].
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse when ciphertext is updated.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state goes to IDLE, all counters and accumulators clear.
  - ciphertext = 0, busy = 0, done = 0.
- Caller contract: every input coefficient lies in [-16,16]. Under this contract the 32-bit accumulators cannot overflow. Behaviour outside the contract is undefined.
- FSM states: IDLE, MAC, REDUCE.
- IDLE:
  - On start = 1 at edge E0: snapshot all inputs into internal registers, clear the 3x4 accumulators, zero all counters, go to MAC, busy = 1.
  - Inputs may change freely after E0.
- MAC: one product per cycle.
  - Nested counters, outer to inner: p (0..2, output polynomial: u0, u1, v), j (0..1), a (0..3), b (0..3).
  - Operand X = A[j][p] for p < 2 (transpose indexing); X = t_j for p = 2.
  - prod = X[a] * r_j[b]; k = (a+b) mod 4.
  - acc[p][k] += prod if a+b < 4; acc[p][k] -= prod if a+b >= 4 (negacyclic wrap).
  - 96 cycles total, at edges E1..E96. After the last product, go to REDUCE.
- REDUCE (edge E97):
  - ciphertext[0][i][k] = mod_Q(acc[i][k] + e1[i][k]).
  - ciphertext[1][0][k] = mod_Q(acc[2][k] + e2[k] + (message[k] ? HALF_Q : 0)).
  - ciphertext[1][1] = 0.
  - mod_Q(x) = ((x % Q) + Q) % Q, giving a result in [0,Q-1] for negative x.
  - done = 1 for exactly this cycle; busy = 0; state returns to IDLE.
- Latency: done and the new ciphertext are visible 97 cycles after the start edge.
- start while busy: ignored. No queuing, no restart.
- start high in the cycle done is asserted: not accepted (the FSM is in REDUCE). It is accepted on the following cycle if still high.
- Start held high continuously: back-to-back operations, one every 98 cycles.
- ciphertext holds its value between operations. It changes only at REDUCE or at reset.

Test Plan:
- Zero keys, zero r/e, message = 4'b1010:
  - ciphertext[1][0] = {0,9,0,9} (coef0..3); u0 = u1 = 0.
  - done pulses exactly 97 cycles after start; busy is high for 96 cycles.
- Negacyclic wrap: pk_t[0] = x^3 ({0,0,0,1}), r_vec[0] = x ({0,1,0,0}), all else 0, message = 0:
  - v = {16,0,0,0}, since x^4 = -1 maps to 16.
- Transpose and noise: pk_a[1][0] = {1,0,0,0}, r_vec[1] = {2,3,0,0}, e1[0] = {-1,0,0,0}, all else 0:
  - u0 = {1,3,0,0}; u1 = {0,0,0,0}.
- Handshake robustness:
  - start pulsed again at cycles 10 and 50 of a run: ignored, single done at 97.
  - rst_n low at cycle 40: ciphertext, busy and done go to 0 immediately.
  - A new start after reset completes a full 97-cycle run with correct results.
- Round trip:
  - Generate a keypair in the bench: s, e in {-1,0,1}; t = A*s + e mod Q. Draw r, e1, e2 in {-1,0,1}.
  - Encrypt all 16 messages, each with 20 random seeds, and feed ciphertext to the decryptor.
  - Required: decimal_value == message in every case.
- Back-to-back: start held high for 3 operations:
  - done pulses at cycles 97, 195, 293.
  - Each ciphertext matches the reference model for the inputs present at its acceptance edge.

Source files
------------

// File: rtl/kyber_encrypt.sv
// Baby-Kyber encryptor over Z_17[x]/(x^4+1), rank 2: u = A^T r + e1, v = t^T r + e2 + encode(m).
// One multiply-accumulate per cycle, 96 products, then one reduction cycle.
module kyber_encrypt #(
  parameter logic signed [31:0] Q      = 32'sd17,
  parameter logic signed [31:0] HALF_Q = 32'sd9
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [3:0]                       message,
  input  logic signed [1:0][1:0][3:0][31:0] pk_a,
  input  logic signed [1:0][3:0][31:0]      pk_t,
  input  logic signed [1:0][3:0][31:0]      r_vec,
  input  logic signed [1:0][3:0][31:0]      e1,
  input  logic signed [3:0][31:0]           e2,
  output logic signed [1:0][1:0][3:0][31:0] ciphertext,
  output logic                             busy,
  output logic                             done
);

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, REDUCE = 2'd2} state_t;

  state_t state_r, state_s;

  logic [1:0][1:0][3:0][31:0] a_key_r;
  logic [1:0][3:0][31:0]      t_key_r;
  logic [1:0][3:0][31:0]      r_key_r;
  logic [1:0][3:0][31:0]      e1_key_r;
  logic [3:0][31:0]           e2_key_r;
  logic [3:0]                 msg_r;

  logic [2:0][3:0][31:0]      acc_r;
  logic [1:0]                 p_r, ca_r, cb_r;
  logic                       j_r;

  logic signed [31:0]         op_x_s, op_y_s, prod_s, acc_cur_s, acc_upd_s;
  logic [1:0]                 k_s;
  logic                       wrap_s, last_s;
  logic [1:0][1:0][3:0][31:0] ct_next_s;

  logic [1:0][1:0][3:0][31:0] ct_r;
  logic                       busy_r, done_r;

  function automatic logic signed [31:0] mod_q(input logic signed [31:0] x);
    logic signed [31:0] r;
    r = x % Q;
    if (r < 32'sd0) r = r + Q;
    else            r = r;
    return r;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start) state_s = MAC; else state_s = IDLE;
      MAC:     if (last_s) state_s = REDUCE; else state_s = MAC;
      REDUCE:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand selection and product; row p<2 uses column p of A (transpose), row 2 uses t
  always_comb begin
    op_x_s = 32'sd0;
    if (p_r == 2'd2) op_x_s = $signed(t_key_r[j_r][ca_r]);
    else             op_x_s = $signed(a_key_r[j_r][p_r[0]][ca_r]);
    op_y_s    = $signed(r_key_r[j_r][cb_r]);
    prod_s    = op_x_s * op_y_s;
    k_s       = ca_r + cb_r;
    wrap_s    = ({1'b0, ca_r} + {1'b0, cb_r}) > 3'd3;
    last_s    = (p_r == 2'd2) && j_r && (ca_r == 2'd3) && (cb_r == 2'd3);
    acc_cur_s = $signed(acc_r[p_r][k_s]);
    // x^4 = -1: products landing past x^3 are subtracted
    if (wrap_s) acc_upd_s = acc_cur_s - prod_s;
    else        acc_upd_s = acc_cur_s + prod_s;
  end

  // Input snapshot, nested counters and accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_key_r  <= '0;
      t_key_r  <= '0;
      r_key_r  <= '0;
      e1_key_r <= '0;
      e2_key_r <= '0;
      msg_r    <= 4'd0;
      acc_r    <= '0;
      p_r      <= 2'd0;
      j_r      <= 1'b0;
      ca_r     <= 2'd0;
      cb_r     <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_key_r  <= pk_a;
            t_key_r  <= pk_t;
            r_key_r  <= r_vec;
            e1_key_r <= e1;
            e2_key_r <= e2;
            msg_r    <= message;
            acc_r    <= '0;
            p_r      <= 2'd0;
            j_r      <= 1'b0;
            ca_r     <= 2'd0;
            cb_r     <= 2'd0;
          end
        end
        MAC: begin
          acc_r[p_r][k_s] <= acc_upd_s;
          cb_r            <= cb_r + 2'd1;
          if (cb_r == 2'd3) begin
            ca_r <= ca_r + 2'd1;
            if (ca_r == 2'd3) begin
              j_r <= ~j_r;
              if (j_r) p_r <= p_r + 2'd1;
            end
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  // Final reduction into [0,Q-1] with noise and message encoding
  always_comb begin
    ct_next_s = '0;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin
        ct_next_s[0][i][k] = mod_q($signed(acc_r[i][k]) + $signed(e1_key_r[i][k]));
      end
    end
    for (int k = 0; k < 4; k++) begin
      ct_next_s[1][0][k] = mod_q($signed(acc_r[2][k]) + $signed(e2_key_r[k])
                                 + (msg_r[k] ? HALF_Q : 32'sd0));
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE:    busy_r <= start;
        MAC:     busy_r <= ~last_s;
        REDUCE: begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
          ct_r   <= ct_next_s;
        end
        default: busy_r <= 1'b0;
      endcase
    end
  end

  assign ciphertext = ct_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_kyber_encrypt.sv
// Scoreboard bench for kyber_encrypt: directed vectors, handshake/reset, back-to-back, round trip.
module tb_kyber_encrypt;

  typedef logic [1:0][1:0][3:0][31:0] ct_t;
  typedef logic [1:0][3:0][31:0]      pv_t;
  typedef logic [3:0][31:0]           poly_t;
  typedef struct { ct_t ct; int cyc; int msg; } exp_t;

  logic  clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [3:0] message = 4'd0;
  ct_t   pk_a = '0;
  pv_t   pk_t = '0, r_vec = '0, e1 = '0;
  poly_t e2 = '0;
  ct_t   ciphertext;
  logic  busy, done;

  int   nvec = 0, nerr = 0, cyc = 0, busy_cnt = 0, dec_v = 0;
  bit   fin_req = 1'b0;
  exp_t exp_q[$];
  exp_t got_e;
  pv_t  key_s, key_e;

  kyber_encrypt dut (
    .clk(clk), .rst_n(rst_n), .start(start), .message(message),
    .pk_a(pk_a), .pk_t(pk_t), .r_vec(r_vec), .e1(e1), .e2(e2),
    .ciphertext(ciphertext), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int modq(input int x);
    int r;
    r = x % 17;
    if (r < 0) r = r + 17;
    return r;
  endfunction

  // coefficient k of x*y mod (x^4+1): full product, then fold the upper half
  function automatic int pmul_coef(input poly_t x, input poly_t y, input int k);
    int full [8];
    for (int n = 0; n < 8; n++) full[n] = 0;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        full[a+b] = full[a+b] + $signed(x[a]) * $signed(y[b]);
    return full[k] - full[k+4];
  endfunction

  function automatic ct_t ref_enc(input ct_t a, input pv_t t, input pv_t r,
                                  input pv_t ee1, input poly_t ee2, input logic [3:0] m);
    ct_t c;
    int  s;
    c = '0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) begin
        s = $signed(ee1[i][k]);
        for (int j = 0; j < 2; j++) s = s + pmul_coef(a[j][i], r[j], k);
        c[0][i][k] = modq(s);
      end
    for (int k = 0; k < 4; k++) begin
      s = $signed(ee2[k]) + (m[k] ? 9 : 0);
      for (int j = 0; j < 2; j++) s = s + pmul_coef(t[j], r[j], k);
      c[1][0][k] = modq(s);
    end
    return c;
  endfunction

  function automatic int decrypt(input ct_t c, input pv_t s);
    int w, res;
    res = 0;
    for (int k = 0; k < 4; k++) begin
      w = $signed(c[1][0][k]);
      for (int i = 0; i < 2; i++) w = w - pmul_coef(s[i], c[0][i], k);
      w = modq(w);
      if (w >= 5 && w <= 12) res = res | (1 << k);
    end
    return res;
  endfunction

  function automatic bit noise_ok();
    int n;
    for (int k = 0; k < 4; k++) begin
      n = $signed(e2[k]);
      for (int j = 0; j < 2; j++) n = n + pmul_coef(key_e[j], r_vec[j], k) - pmul_coef(key_s[j], e1[j], k);
      if (n > 3 || n < -3) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(hi - lo, 0));
  endfunction

  // Monitor: reset-state checks, and one scoreboard pop per done pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      busy_cnt = 0;
      nvec++;
      if (ciphertext !== '0 || busy !== 1'b0 || done !== 1'b0) begin
        nerr++;
        $display("FAIL reset_state ct=%h busy=%b done=%b, required all zero", ciphertext, busy, done);
      end
    end else begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          got_e = exp_q.pop_front();
          if (ciphertext !== got_e.ct) begin
            nerr++;
            $display("FAIL ciphertext got %h required %h", ciphertext, got_e.ct);
          end
          nvec++;
          if (cyc != got_e.cyc) begin
            nerr++;
            $display("FAIL done_cycle got %0d required %0d", cyc, got_e.cyc);
          end
          nvec++;
          if (busy_cnt != 96) begin
            nerr++;
            $display("FAIL busy_length got %0d required 96", busy_cnt);
          end
          if (got_e.msg >= 0) begin
            nvec++;
            dec_v = decrypt(ciphertext, key_s);
            if (dec_v != got_e.msg) begin
              nerr++;
              $display("FAIL round_trip decoded %0d required %0d", dec_v, got_e.msg);
            end
          end
        end
        busy_cnt = 0;
      end
    end
    if (fin_req) begin
      nvec++;
      if (exp_q.size() != 0) begin
        nerr++;
        $display("FAIL missing_done %0d outstanding, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
    end
  end

  task automatic expect_at(input ct_t c, input int at, input int m);
    exp_t x;
    x.ct = c; x.cyc = at; x.msg = m;
    exp_q.push_back(x);
  endtask

  task automatic issue(input ct_t c, input int m);
    expect_at(c, cyc + 98, m);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic set_zero();
    pk_a = '0; pk_t = '0; r_vec = '0; e1 = '0; e2 = '0; message = 4'd0;
  endtask

  task automatic rand_in();
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < 2; i++) pk_a[j][i][k] = rnd(-16, 16);
        pk_t[j][k]  = rnd(-16, 16);
        r_vec[j][k] = rnd(-16, 16);
        e1[j][k]    = rnd(-16, 16);
      end
    for (int k = 0; k < 4; k++) e2[k] = rnd(-16, 16);
    message = 4'(rnd(0, 15));
  endtask

  // Stimulus
  initial begin
    ct_t want;
    int  a0, s;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // zero keys, message 1010 -> v = {0,9,0,9}
    set_zero(); message = 4'b1010;
    want = '0; want[1][0][1] = 32'd9; want[1][0][3] = 32'd9;
    issue(want, -1); wait_done(200);

    // x^3 * x = x^4 = -1 -> 16
    set_zero(); pk_t[0][3] = 32'd1; r_vec[0][1] = 32'd1;
    want = '0; want[1][0][0] = 32'd16;
    issue(want, -1); wait_done(200);

    // A[1][0] feeds u0; u0 = {2,3,0,0} + {-1,0,0,0}
    set_zero(); pk_a[1][0][0] = 32'd1; r_vec[1][0] = 32'd2; r_vec[1][1] = 32'd3; e1[0][0] = -32'sd1;
    want = '0; want[0][0][0] = 32'd1; want[0][0][1] = 32'd3;
    issue(want, -1); wait_done(200);

    // extra start pulses during the run are ignored; v = {-1+9,0,9,0}
    set_zero(); pk_t[0][3] = 32'd1; r_vec[0][1] = 32'd1; message = 4'b0101;
    want = '0; want[1][0][0] = 32'd8; want[1][0][2] = 32'd9;
    issue(want, -1);
    repeat (9) @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (39) @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(200);

    // reset at cycle 40, then a full run: u0 = (1+x)(x^2+x^3) = {16,0,1,2}, v = e2 = {1,0,0,0}
    set_zero(); pk_a[0][0][0] = 32'd1; pk_a[0][0][1] = 32'd1;
    r_vec[0][2] = 32'd1; r_vec[0][3] = 32'd1; e2[0] = 32'd1;
    want = '0; want[0][0][0] = 32'd16; want[0][0][2] = 32'd1; want[0][0][3] = 32'd2; want[1][0][0] = 32'd1;
    issue(want, -1);
    repeat (39) @(posedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(want, -1); wait_done(200);

    // back-to-back with start held high; inputs change after each acceptance
    rand_in();
    expect_at(ref_enc(pk_a, pk_t, r_vec, e1, e2, message), cyc + 98, -1);
    start = 1'b1;
    @(posedge clk); #1;
    a0 = cyc;
    rand_in();
    expect_at(ref_enc(pk_a, pk_t, r_vec, e1, e2, message), a0 + 195, -1);
    repeat (98) @(posedge clk); #1;
    rand_in();
    expect_at(ref_enc(pk_a, pk_t, r_vec, e1, e2, message), a0 + 293, -1);
    repeat (98) @(posedge clk); #1;
    start = 1'b0;
    wait_done(400);

    // round trip through the decryptor with a bench-generated keypair
    set_zero();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) begin
        key_s[i][k] = rnd(-1, 1);
        key_e[i][k] = rnd(-1, 1);
        for (int j = 0; j < 2; j++) pk_a[i][j][k] = rnd(0, 16);
      end
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < 4; k++) begin
        s = $signed(key_e[j][k]);
        for (int i = 0; i < 2; i++) s = s + pmul_coef(pk_a[j][i], key_s[i], k);
        pk_t[j][k] = modq(s);
      end
    for (int m = 0; m < 16; m++) begin
      for (int seed = 0; seed < 20; seed++) begin
        // redraw until the decryption noise stays inside the decision margin
        for (int tries = 0; tries < 200; tries++) begin
          for (int j = 0; j < 2; j++)
            for (int k = 0; k < 4; k++) begin
              r_vec[j][k] = rnd(-1, 1);
              e1[j][k]    = rnd(-1, 1);
            end
          for (int k = 0; k < 4; k++) e2[k] = rnd(-1, 1);
          if (noise_ok()) break;
        end
        message = 4'(m);
        issue(ref_enc(pk_a, pk_t, r_vec, e1, e2, message), m);
        wait_done(200);
      end
    end

    repeat (2) @(posedge clk);
    fin_req = 1'b1;
    repeat (4) @(negedge clk);
    $display("FAIL summary_not_reached");
    $fatal(1);
  end

endmodule
